// File: rtl/data_memory_ctrl.sv
// Single-port 32-bit data memory with request/response handshake, byte-lane
// stores, sign/zero-extended loads and split handling of unaligned words.
module data_memory_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter bit          DO_INIT     = 1'b0,
  parameter              INIT_FILE   = "data_ram.memh"
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_MASK = ~(32'(4 * DEPTH_WORDS) - 32'd1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane mask over two consecutive words: low nibble word A, high nibble A+1.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] steer_wdata(input logic [31:0] wdata, input logic [1:0] off);
    return {32'd0, wdata} << {off, 3'b000};
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                              input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (size)
      2'd0:    return sgn ? 32'(b) : {24'd0, raw[7:0]};
      2'd1:    return sgn ? 32'(h) : {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  logic [AW-1:0] req_idx;
  logic [1:0]    req_off;
  logic          req_bad;
  logic          accept;

  assign req_idx = req_addr[AW+1:2];
  assign req_off = req_addr[1:0];
  assign accept  = req_valid && (state == IDLE);

  always_comb begin
    req_bad = (req_addr & WIN_MASK) != BASE_ADDR;
    case (req_size)
      2'd1:    if (req_off[0]) req_bad = 1'b1;
      2'd2:    if (req_off != 2'd0 && req_idx == {AW{1'b1}}) req_bad = 1'b1;
      2'd3:    if (req_off != 2'd0) req_bad = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: request captured at accept, held for the whole transaction
  logic [AW-1:0] idx_p0;
  logic [1:0]    off_p0, size_p0;
  logic          we_p0, sgn_p0, err_p0;
  logic [31:0]   wdata_p0;

  always_ff @(posedge clock) begin
    if (accept) begin
      idx_p0   <= req_idx;
      off_p0   <= req_off;
      size_p0  <= req_size;
      we_p0    <= req_we;
      sgn_p0   <= req_signed;
      wdata_p0 <= req_wdata;
      err_p0   <= req_bad;
    end
  end

  logic          split;
  logic [7:0]    mask_w;
  logic [63:0]   wide_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_en;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wd;

  assign split      = (size_p0 == 2'd2) && (off_p0 != 2'd0);
  assign mask_w     = lane_mask(size_p0, off_p0);
  assign wide_wdata = steer_wdata(wdata_p0, off_p0);
  assign acc_en     = ((state == ACC0) || (state == ACC1)) && !err_p0;
  assign acc_idx    = (state == ACC1) ? idx_p0 + AW'(1) : idx_p0;
  assign acc_be     = (state == ACC1) ? mask_w[7:4] : mask_w[3:0];
  assign acc_wd     = (state == ACC1) ? wide_wdata[63:32] : wide_wdata[31:0];

  // Stage p1: array access; read words A / A+1 land in rd0_p1 / rd1_p1
  logic [31:0] rd0_p1, rd1_p1;

  always_ff @(posedge clock) begin
    if (acc_en) begin
      if (we_p0) begin
        for (int l = 0; l < 4; l++) begin
          if (acc_be[l]) mem[acc_idx][8*l +: 8] <= acc_wd[8*l +: 8];
        end
      end
      if (state == ACC0) rd0_p1 <= mem[acc_idx];
      else               rd1_p1 <= mem[acc_idx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC0;
      ACC0:    state_nxt = (split && !err_p0) ? ACC1 : RESP;
      ACC1:    state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: response assembled from the read words, gated to the RESP cycle
  logic [31:0] raw_p2;

  assign raw_p2     = 32'({rd1_p1, rd0_p1} >> {off_p0, 3'b000});
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_p0;
  assign resp_rdata = ((state == RESP) && !err_p0 && !we_p0) ?
                      load_extend(raw_p2, size_p0, sgn_p0) : 32'd0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: stores/loads, extension, split accesses,
// error cases, back-to-back requests and reset during a split store.
module tb_data_memory_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  data_memory_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
    req_addr   = a;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
  endtask

  // Issues one request and checks latency (cycles after accept), rdata and err.
  task automatic do_req(input string tag, input logic [31:0] a, input logic we,
                        input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                        input int elat, input logic [31:0] erd, input logic eerr);
    int lat;
    lat = -1;
    @(negedge clock);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    set_req(a, we, sz, sg, wd);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    check({tag, ".rdata"}, resp_rdata, erd);
    check({tag, ".err"}, 32'(resp_err), 32'(eerr));
  endtask

  initial begin
    logic [31:0] exp_q [3];
    int nresp, busy, ridx;

    #3;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err", 32'(resp_err), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    do_req("st_word", 32'h1000_0008, 1, 2'd3, 0, 32'hDEADBEEF, 2, 32'h0, 0);
    do_req("ld_word", 32'h1000_0008, 0, 2'd3, 0, 32'h0, 2, 32'hDEADBEEF, 0);

    do_req("st_byte", 32'h1000_0009, 1, 2'd0, 0, 32'h0000_0080, 2, 32'h0, 0);
    do_req("ld_bs", 32'h1000_0009, 0, 2'd0, 1, 32'h0, 2, 32'hFFFF_FF80, 0);
    do_req("ld_bu", 32'h1000_0009, 0, 2'd0, 0, 32'h0, 2, 32'h0000_0080, 0);
    do_req("ld_w8", 32'h1000_0008, 0, 2'd3, 1, 32'h0, 2, 32'hDEAD80EF, 0);
    do_req("ld_hs", 32'h1000_000A, 0, 2'd1, 1, 32'h0, 2, 32'hFFFF_DEAD, 0);
    do_req("ld_hu", 32'h1000_0008, 0, 2'd1, 0, 32'h0, 2, 32'h0000_80EF, 0);

    do_req("st_z10", 32'h1000_0010, 1, 2'd3, 0, 32'h0, 2, 32'h0, 0);
    do_req("st_z14", 32'h1000_0014, 1, 2'd3, 0, 32'h0, 2, 32'h0, 0);
    do_req("st_split", 32'h1000_0013, 1, 2'd2, 0, 32'h11223344, 3, 32'h0, 0);
    do_req("ld_w10", 32'h1000_0010, 0, 2'd3, 0, 32'h0, 2, 32'h44000000, 0);
    do_req("ld_w14", 32'h1000_0014, 0, 2'd3, 0, 32'h0, 2, 32'h00112233, 0);
    do_req("ld_split", 32'h1000_0013, 0, 2'd2, 0, 32'h0, 3, 32'h11223344, 0);

    do_req("st_w0", 32'h1000_0000, 1, 2'd3, 0, 32'h01020304, 2, 32'h0, 0);
    do_req("st_wlast", 32'h1000_0FFC, 1, 2'd3, 0, 32'hCAFEF00D, 2, 32'h0, 0);
    do_req("err_w_mis", 32'h1000_0002, 1, 2'd3, 0, 32'hFFFFFFFF, 2, 32'h0, 1);
    do_req("err_h_odd", 32'h1000_0001, 1, 2'd1, 0, 32'hFFFFFFFF, 2, 32'h0, 1);
    do_req("err_win", 32'h2000_0000, 0, 2'd3, 0, 32'h0, 2, 32'h0, 1);
    do_req("err_wrap", 32'h1000_0FFD, 1, 2'd2, 0, 32'hFFFFFFFF, 2, 32'h0, 1);
    do_req("ld_w0", 32'h1000_0000, 0, 2'd3, 0, 32'h0, 2, 32'h01020304, 0);
    do_req("ld_wlast", 32'h1000_0FFC, 0, 2'd3, 0, 32'h0, 2, 32'hCAFEF00D, 0);

    // Three loads queued with req_valid held high
    exp_q[0] = 32'hDEAD80EF;
    exp_q[1] = 32'h44000000;
    exp_q[2] = 32'h00112233;
    nresp = 0;
    busy  = 0;
    ridx  = 0;
    @(negedge clock);
    set_req(32'h1000_0008, 0, 2'd3, 0, 32'h0);
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clock);
      if (resp_valid) begin
        if (nresp < 3) check($sformatf("b2b.rd%0d", nresp), resp_rdata, exp_q[nresp]);
        nresp++;
      end
      if (!req_ready) busy++;
      if (req_ready && req_valid) begin
        @(posedge clock);
        #1;
        ridx++;
        if (ridx == 1) set_req(32'h1000_0010, 0, 2'd3, 0, 32'h0);
        else if (ridx == 2) set_req(32'h1000_0014, 0, 2'd3, 0, 32'h0);
        else req_valid = 1'b0;
      end
    end
    check("b2b.count", 32'(nresp), 32'd3);
    check("b2b.busy", 32'(busy), 32'd6);

    // Reset asserted during ACC1 of a split store
    do_req("st_w20", 32'h1000_0020, 1, 2'd3, 0, 32'hAAAAAAAA, 2, 32'h0, 0);
    do_req("st_w24", 32'h1000_0024, 1, 2'd3, 0, 32'hBBBBBBBB, 2, 32'h0, 0);
    @(negedge clock);
    set_req(32'h1000_0022, 1, 2'd2, 0, 32'h55667788);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rsplit.busy", 32'(req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rsplit.ready", 32'(req_ready), 32'd1);
    check("rsplit.valid", 32'(resp_valid), 32'd0);
    check("rsplit.rdata", resp_rdata, 32'd0);
    check("rsplit.err", 32'(resp_err), 32'd0);
    @(posedge clock);
    #1 check("rsplit.noresp", 32'(resp_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_req("ld_w20", 32'h1000_0020, 0, 2'd3, 0, 32'h0, 2, 32'h7788AAAA, 0);
    do_req("ld_w24", 32'h1000_0024, 0, 2'd3, 0, 32'h0, 2, 32'hBBBBBBBB, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
